ace_mem_slave: RTL and testbench
================================

Name: ace_mem_slave

Overview:
- Simulation and FPGA memory target that sits directly downstream of the offnariscv_core ACE master port. It terminates core_ace_if in place of a real interconnect.
- Services AR/R read bursts and AW/W/B write bursts against a line-wide memory array.
- Ties off the snoop channels (AC/CR/CD); the core is the only master.
- Used by the core test harness and the Kanata trace flow as the backing instruction and data store.

Parameters:
- XDATA_WIDTH, 256, data bus width in bits; one memory word is one cache line.
- AXADDR_WIDTH, 32, address width.
- MEM_DEPTH, 4096, number of XDATA_WIDTH-bit words; power of two.
- READ_LATENCY, 2, cycles from AR handshake to first rvalid; range 1..15.
- INIT_FILE, "", hex file loaded with $readmemh at time 0 when non-empty.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- ace  interface  ace_if.slave  full ACE slave side: AW, W, B, AR, R, AC, CR, CD, rack, wack.
- rd_bursts  output  32  count of completed read bursts (rlast handshakes).
- wr_bursts  output  32  count of completed write bursts (B handshakes).

Behaviour:
- Address decode
  - word index = addr >> log2(XDATA_WIDTH/8).
  - In range iff index < MEM_DEPTH; an out-of-range burst is flagged for its whole length.
  - Narrow axsize is not supported: every beat advances by one word.
- Burst address, computed by the sub-module, per beat
  - INCR: index+1.
  - FIXED: index unchanged.
  - WRAP: wraps within the aligned (len+1)-word window; len must be 1, 3, 7 or 15.
- Read FSM: R_IDLE, R_WAIT, R_DATA
  - arready = 1 only in R_IDLE, and never while rst is high.
  - AR handshake latches arid, index, arlen, arburst and the out-of-range flag, loads the latency counter with READ_LATENCY-1, and enters R_WAIT (or R_DATA directly when READ_LATENCY = 1).
  - R_WAIT counts down; at 0 it enters R_DATA.
  - R_DATA: rvalid = 1; rid = latched arid; rdata = mem[index], or 0 when out of range.
  - rresp[1:0] = 2'b00 OKAY, or 2'b11 DECERR when out of range; rresp[3:2] = 0 (never PassDirty or IsShared).
  - rlast = (beat == arlen).
  - rdata, rid and rresp are held stable while rvalid=1 and rready=0.
  - On a beat handshake: beat+1 and the address advances. On the rlast handshake: rd_bursts+1 and the FSM returns to R_IDLE. arready reasserts the following cycle; there is no AR/rlast overlap.
- Write FSM: W_IDLE, W_DATA, W_RESP
  - awready = 1 only in W_IDLE.
  - AW handshake latches awid, index, awlen, awburst and the range flag, and clears the error flag.
  - W_DATA: wready = 1. Each handshake writes the bytes where wstrb[i]=1 (only when in range), then beat+1 and the address advances.
  - If wlast does not coincide with beat == awlen, the error flag is set. On a missing wlast, writes stop after beat awlen and the FSM keeps accepting and discarding beats until wlast.
  - The wlast handshake moves the FSM to W_RESP.
  - W_RESP: bvalid = 1, bid = awid, bresp = OKAY, SLVERR on error, DECERR if out of range. Held until bready; then wr_bursts+1 and return to W_IDLE.
- Read/write concurrency
  - Both FSMs run independently.
  - A same-cycle write beat and read of the same word returns the old data; the write lands at the clock edge.
- Snoop tie-off and ack inputs
  - acvalid = 0, acaddr = 0, acsnoop = 0, acprot = 0.
  - crready = 1 and cdready = 1 (outside reset).
  - rack and wack are ignored.
- Reset
  - Both FSMs go to idle; beat and latency counters clear; rd_bursts and wr_bursts = 0.
  - All valid/ready outputs = 0 during rst; data outputs = 0.
  - Memory contents are preserved across reset.
  - Reset in mid-burst abandons the burst with no response.

Decomposition:
- offnariscv_pkg gains:
  - ace_burst_e: FIXED=0, INCR=1, WRAP=2.
  - ace_resp_e: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
- Sub-module ace_burst_addr (combinational): inputs index, len and burst type; output next index. Instantiated once by the read FSM and once by the write FSM.

Test Plan:
- Reset, then preload mem[0..3] = 0x11.., 0x22.., 0x33.., 0x44.. → AR addr=0, len=3, INCR, id=5 returns 4 beats in that order, first rvalid 2 cycles after AR, rlast on beat 3, rid=5, rresp=0, rd_bursts=1.
- WRAP read addr=0x40 (index 2), len=3 → beat indices 2, 3, 0, 1.
- Read at addr=0x0002_0000 with MEM_DEPTH=4096 → rdata=0, rresp[1:0]=3; a DECERR write to the same address leaves memory unchanged.
- AW addr=0x20, len=1, id=2; W beats with wstrb=0xFFFF_0000 and 0xFFFF_FFFF → only the upper 16 bytes of word 1 change, word 2 is fully written, bid=2, bresp=0 after wlast; B held 3 cycles with bready=0.
- W with wlast on beat 0 of a len=1 burst → bresp=SLVERR (2); wlast missing on beat 1 → extra beats discarded until wlast, bresp=2.
- rready toggled 1-0-1 during a 4-beat read → no beat lost or duplicated, rdata stable while stalled; rst asserted mid-burst → rvalid drops, arready=1 one cycle after reset, memory intact.

Source files
------------

// File: rtl/offnariscv_pkg.sv
// Shared ACE types for the offnariscv core and its memory-side collaborators.
// Contents:
//   ace_burst_e - AxBURST encodings (FIXED, INCR, WRAP)
//   ace_resp_e  - xRESP[1:0] encodings (OKAY, EXOKAY, SLVERR, DECERR)
//   rd_state_e  - ace_mem_slave read-channel FSM states
//   wr_state_e  - ace_mem_slave write-channel FSM states
package offnariscv_pkg;

  localparam int ACE_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } ace_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } ace_resp_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/ace_if.sv
// ACE link between the offnariscv core (master) and its memory side (slave).
// Channels: AW, W, B, AR, R (read/write), AC, CR, CD (snoop), rack/wack.
// Modports:
//   master - core side
//   slave  - memory / interconnect side
interface ace_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4
);

  // Write address
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // Write data
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // Read data
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [3:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  // Snoop address
  logic                    acvalid;
  logic                    acready;
  logic [ADDR_WIDTH-1:0]   acaddr;
  logic [3:0]              acsnoop;
  logic [2:0]              acprot;
  // Snoop response
  logic                    crvalid;
  logic                    crready;
  logic [4:0]              crresp;
  // Snoop data
  logic                    cdvalid;
  logic                    cdready;
  logic [DATA_WIDTH-1:0]   cddata;
  logic                    cdlast;
  // Acknowledges
  logic                    rack;
  logic                    wack;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready,
    input acvalid, acaddr, acsnoop, acprot, output acready,
    output crvalid, crresp, input crready,
    output cdvalid, cddata, cdlast, input cdready,
    output rack, wack
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    output acvalid, acaddr, acsnoop, acprot, input acready,
    input crvalid, crresp, output crready,
    input cdvalid, cddata, cdlast, output cdready,
    input rack, wack
  );

endinterface

// File: rtl/ace_burst_addr.sv
// Next-beat word index for an ACE burst (combinational).
// Ports:
//   index      - current word index
//   len        - AxLEN of the burst (beats - 1)
//   burst      - burst type
//   next_index - word index of the following beat
// WRAP keeps the low log2(len+1) index bits cycling inside the aligned
// window; len is assumed to be 1, 3, 7 or 15 so len itself is the mask.
module ace_burst_addr
  import offnariscv_pkg::*;
#(
  parameter int IDX_WIDTH = 12
) (
  input  logic [IDX_WIDTH-1:0]     index,
  input  logic [ACE_LEN_WIDTH-1:0] len,
  input  ace_burst_e               burst,
  output logic [IDX_WIDTH-1:0]     next_index
);

  logic [IDX_WIDTH-1:0] wrap_mask;
  logic [IDX_WIDTH-1:0] incr_index;
  logic                 unused_len_hi;

  assign wrap_mask     = IDX_WIDTH'(len[3:0]);
  assign incr_index    = index + IDX_WIDTH'(1);
  assign unused_len_hi = ^len[ACE_LEN_WIDTH-1:4];

  always_comb begin
    next_index = incr_index;
    case (burst)
      FIXED:   next_index = index;
      INCR:    next_index = incr_index;
      WRAP:    next_index = (index & ~wrap_mask) | (incr_index & wrap_mask);
      default: next_index = incr_index;
    endcase
  end

endmodule

// File: rtl/ace_mem_slave.sv
// Line-wide memory terminating the offnariscv core ACE master port.
// Services AR/R and AW/W/B bursts from one XDATA_WIDTH-bit-per-word array and
// ties off the snoop channels (the core is the only master).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   ace       - ACE slave side
//   rd_bursts - completed read bursts (rlast handshakes)
//   wr_bursts - completed write bursts (B handshakes)
module ace_mem_slave
  import offnariscv_pkg::*;
#(
  parameter int    XDATA_WIDTH  = 256,
  parameter int    AXADDR_WIDTH = 32,
  parameter int    MEM_DEPTH    = 4096,
  parameter int    READ_LATENCY = 2,
  parameter int    ID_WIDTH     = 4,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst,
  ace_if.slave        ace,
  output logic [31:0] rd_bursts,
  output logic [31:0] wr_bursts
);

  localparam int OFF_W = $clog2(XDATA_WIDTH/8);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NBYTE = XDATA_WIDTH/8;

  logic [XDATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------- read side
  rd_state_e              rd_state, rd_state_next;
  logic [ID_WIDTH-1:0]    r_id;
  logic [IDX_W-1:0]       r_idx, r_next_idx;
  logic [7:0]             r_len, r_beat;
  ace_burst_e             r_burst;
  logic                   r_oor;
  logic [3:0]             r_cnt;
  logic [XDATA_WIDTH-1:0] r_data;
  logic                   ar_fire, r_fire, r_last, rd_valid;
  logic [IDX_W-1:0]       ar_idx;
  logic                   ar_oor;

  assign ar_idx   = ace.araddr[OFF_W +: IDX_W];
  assign ar_oor   = |ace.araddr[AXADDR_WIDTH-1:OFF_W+IDX_W];
  assign rd_valid = (rd_state == R_DATA) && !rst;
  assign ar_fire  = ace.arvalid && (rd_state == R_IDLE) && !rst;
  assign r_fire   = rd_valid && ace.rready;
  assign r_last   = (r_beat == r_len);

  ace_burst_addr #(.IDX_WIDTH(IDX_W)) u_rd_addr (
    .index      (r_idx),
    .len        (r_len),
    .burst      (r_burst),
    .next_index (r_next_idx)
  );

  // NOTE: every signal an always_comb drives gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      R_IDLE: if (ar_fire) rd_state_next = (READ_LATENCY == 1) ? R_DATA : R_WAIT;
      // The counter holds READ_LATENCY-1 on entry; leave as it reaches zero.
      R_WAIT: if (r_cnt == 4'd1) rd_state_next = R_DATA;
      R_DATA: if (r_fire && r_last) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      r_id      <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_burst   <= INCR;
      r_oor     <= 1'b0;
      r_beat    <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      rd_bursts <= '0;
    end else begin
      rd_state <= rd_state_next;
      if (ar_fire) begin
        r_id    <= ace.arid;
        r_idx   <= ar_idx;
        r_len   <= ace.arlen;
        r_burst <= ace_burst_e'(ace.arburst);
        r_oor   <= ar_oor;
        r_beat  <= '0;
        r_cnt   <= 4'(READ_LATENCY - 1);
        if (READ_LATENCY == 1) r_data <= mem[ar_idx];
      end
      if (rd_state == R_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) r_data <= mem[r_idx];
      end
      // rdata is registered, so it stays put while stalled and a same-cycle
      // write to the word is only seen on a later beat.
      if (r_fire) begin
        if (r_last) begin
          rd_bursts <= rd_bursts + 32'd1;
        end else begin
          r_beat <= r_beat + 8'd1;
          r_idx  <= r_next_idx;
          r_data <= mem[r_next_idx];
        end
      end
    end
  end

  assign ace.arready = (rd_state == R_IDLE) && !rst;
  assign ace.rvalid  = rd_valid;
  assign ace.rid     = rst ? '0 : r_id;
  assign ace.rdata   = (rst || r_oor) ? '0 : r_data;
  assign ace.rresp   = rst ? 4'd0 : {2'b00, r_oor ? DECERR : OKAY};
  assign ace.rlast   = rd_valid && r_last;

  // --------------------------------------------------------------- write side
  wr_state_e              wr_state, wr_state_next;
  logic [ID_WIDTH-1:0]    w_id;
  logic [IDX_W-1:0]       w_idx, w_next_idx;
  logic [7:0]             w_len, w_beat;
  ace_burst_e             w_burst;
  logic                   w_oor, w_err, w_done;
  logic                   aw_fire, w_fire, b_fire, w_at_last;

  assign aw_fire   = ace.awvalid && (wr_state == W_IDLE) && !rst;
  assign w_fire    = ace.wvalid && (wr_state == W_DATA) && !rst;
  assign b_fire    = ace.bready && (wr_state == W_RESP) && !rst;
  assign w_at_last = (w_beat == w_len);

  ace_burst_addr #(.IDX_WIDTH(IDX_W)) u_wr_addr (
    .index      (w_idx),
    .len        (w_len),
    .burst      (w_burst),
    .next_index (w_next_idx)
  );

  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_fire) wr_state_next = W_DATA;
      W_DATA:  if (w_fire && ace.wlast) wr_state_next = W_RESP;
      W_RESP:  if (b_fire) wr_state_next = W_IDLE;
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      w_id      <= '0;
      w_idx     <= '0;
      w_len     <= '0;
      w_burst   <= INCR;
      w_oor     <= 1'b0;
      w_err     <= 1'b0;
      w_done    <= 1'b0;
      w_beat    <= '0;
      wr_bursts <= '0;
    end else begin
      wr_state <= wr_state_next;
      if (aw_fire) begin
        w_id    <= ace.awid;
        w_idx   <= ace.awaddr[OFF_W +: IDX_W];
        w_len   <= ace.awlen;
        w_burst <= ace_burst_e'(ace.awburst);
        w_oor   <= |ace.awaddr[AXADDR_WIDTH-1:OFF_W+IDX_W];
        w_err   <= 1'b0;
        w_done  <= 1'b0;
        w_beat  <= '0;
      end
      if (w_fire) begin
        // Sticky: an early wlast or any beat past awlen marks the burst bad.
        if (ace.wlast != w_at_last) w_err <= 1'b1;
        // Past beat awlen the burst keeps draining but stops writing.
        if (w_at_last) w_done <= 1'b1;
        w_beat <= w_beat + 8'd1;
        w_idx  <= w_next_idx;
      end
      if (b_fire) wr_bursts <= wr_bursts + 32'd1;
    end
  end

  // NOTE: the memory array has no reset; contents survive rst, and a reset
  // port would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (w_fire && !w_done && !w_oor) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (ace.wstrb[i]) mem[w_idx][i*8 +: 8] <= ace.wdata[i*8 +: 8];
      end
    end
  end

  assign ace.awready = (wr_state == W_IDLE) && !rst;
  assign ace.wready  = (wr_state == W_DATA) && !rst;
  assign ace.bvalid  = (wr_state == W_RESP) && !rst;
  assign ace.bid     = rst ? '0 : w_id;
  assign ace.bresp   = rst ? 2'd0 : (w_oor ? DECERR : (w_err ? SLVERR : OKAY));

  // ------------------------------------------------------------ snoop tie-off
  assign ace.acvalid = 1'b0;
  assign ace.acaddr  = '0;
  assign ace.acsnoop = '0;
  assign ace.acprot  = '0;
  assign ace.crready = !rst;
  assign ace.cdready = !rst;

  // Narrow sizes, sub-word offsets, snoop responses and acks carry no meaning
  // for a single-master line memory.
  logic unused_inputs;
  assign unused_inputs = ^{ace.araddr[OFF_W-1:0], ace.awaddr[OFF_W-1:0],
                           ace.arsize, ace.awsize, ace.acready, ace.crvalid,
                           ace.crresp, ace.cdvalid, ace.cddata, ace.cdlast,
                           ace.rack, ace.wack};

endmodule

// File: tb/tb_ace_mem_slave.sv
// Directed bench for ace_mem_slave: bursts, wrap, decode errors, strobes,
// wlast errors, R back-pressure and reset mid-burst.
module tb_ace_mem_slave;
  import offnariscv_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] rd_bursts;
  logic [31:0] wr_bursts;
  int          n_checks;
  int          n_errors;

  ace_if #(.ADDR_WIDTH(32), .DATA_WIDTH(256), .ID_WIDTH(4)) bus ();

  ace_mem_slave #(
    .XDATA_WIDTH  (256),
    .AXADDR_WIDTH (32),
    .MEM_DEPTH    (4096),
    .READ_LATENCY (2),
    .ID_WIDTH     (4),
    .INIT_FILE    ("")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ace       (bus),
    .rd_bursts (rd_bursts),
    .wr_bursts (wr_bursts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int i);
    logic [7:0] b;
    b = 8'(8'h11 * (i + 1));
    return {32{b}};
  endfunction

  task automatic aw_send(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
    int t;
    t = 0;
    @(negedge clk);
    bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awburst = burst;
    bus.awvalid = 1'b1;
    while (!bus.awready && t < 50) begin @(negedge clk); t++; end
    check("awready", bus.awready, 1'b1);
    @(posedge clk); #1 bus.awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
    int t;
    t = 0;
    @(negedge clk);
    bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arburst = burst;
    bus.arvalid = 1'b1;
    while (!bus.arready && t < 50) begin @(negedge clk); t++; end
    check("arready", bus.arready, 1'b1);
    @(posedge clk); #1 bus.arvalid = 1'b0;
  endtask

  task automatic w_send(input logic [255:0] data, input logic [31:0] strb, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && t < 50) begin @(negedge clk); t++; end
    check("wready", bus.wready, 1'b1);
    @(posedge clk); #1 bus.wvalid = 1'b0;
  endtask

  task automatic b_expect(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int t;
    t = 0;
    @(negedge clk);
    bus.bready = 1'b1;
    while (!bus.bvalid && t < 50) begin @(negedge clk); t++; end
    check({tag, "_bvalid"}, bus.bvalid, 1'b1);
    check({tag, "_bid"}, bus.bid, id);
    check({tag, "_bresp"}, bus.bresp, resp);
    @(posedge clk); #1 bus.bready = 1'b0;
  endtask

  task automatic r_expect(input string tag, input logic [255:0] data, input logic [3:0] id,
                          input logic [1:0] resp, input logic last, input int stall);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.rvalid && t < 50) begin @(negedge clk); t++; end
    for (int s = 0; s < stall; s++) begin
      check({tag, "_stall_valid"}, bus.rvalid, 1'b1);
      check({tag, "_stall_data"}, bus.rdata, data);
      @(negedge clk);
    end
    bus.rready = 1'b1;
    check({tag, "_rvalid"}, bus.rvalid, 1'b1);
    check({tag, "_rdata"}, bus.rdata, data);
    check({tag, "_rid"}, bus.rid, id);
    check({tag, "_rresp"}, bus.rresp, {2'b00, resp});
    check({tag, "_rlast"}, bus.rlast, last);
    @(posedge clk); #1 bus.rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] w1_exp;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd5; bus.awburst = INCR;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd5;
    bus.arburst = INCR; bus.arvalid = 1'b0; bus.rready = 1'b0; bus.acready = 1'b0;
    bus.crvalid = 1'b0; bus.crresp = '0; bus.cdvalid = 1'b0; bus.cddata = '0;
    bus.cdlast = 1'b0; bus.rack = 1'b0; bus.wack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_crready", bus.crready, 1'b0);
    check("rst_rd_bursts", rd_bursts, 32'd0);
    check("rst_wr_bursts", wr_bursts, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_arready", bus.arready, 1'b1);
    check("idle_crready", bus.crready, 1'b1);
    check("idle_cdready", bus.cdready, 1'b1);
    check("idle_acvalid", bus.acvalid, 1'b0);

    // Preload words 0..7 with 0x11.., 0x22.., ... 0x88..
    aw_send(32'h0, 4'd1, 8'd7, INCR);
    for (int i = 0; i < 8; i++) w_send(pat(i), 32'hFFFF_FFFF, i == 7);
    b_expect("pre", 4'd1, OKAY);
    @(negedge clk);
    check("pre_wr_bursts", wr_bursts, 32'd1);

    // INCR read, 4 beats, latency 2
    ar_send(32'h0, 4'd5, 8'd3, INCR);
    @(negedge clk);
    check("lat_cycle1_rvalid", bus.rvalid, 1'b0);
    @(negedge clk);
    check("lat_cycle2_rvalid", bus.rvalid, 1'b1);
    for (int i = 0; i < 4; i++) r_expect("incr", pat(i), 4'd5, OKAY, i == 3, 0);
    @(negedge clk);
    check("incr_rd_bursts", rd_bursts, 32'd1);
    check("incr_arready_back", bus.arready, 1'b1);

    // WRAP read from index 2: 2, 3, 0, 1
    ar_send(32'h40, 4'd3, 8'd3, WRAP);
    r_expect("wrap0", pat(2), 4'd3, OKAY, 1'b0, 0);
    r_expect("wrap1", pat(3), 4'd3, OKAY, 1'b0, 0);
    r_expect("wrap2", pat(0), 4'd3, OKAY, 1'b0, 0);
    r_expect("wrap3", pat(1), 4'd3, OKAY, 1'b1, 0);

    // Out-of-range read and write (index 4096 aliases word 0 in the low bits)
    ar_send(32'h0002_0000, 4'd7, 8'd0, INCR);
    r_expect("oor_rd", 256'd0, 4'd7, DECERR, 1'b1, 0);
    aw_send(32'h0002_0000, 4'd3, 8'd0, INCR);
    w_send({32{8'hEE}}, 32'hFFFF_FFFF, 1'b1);
    b_expect("oor_wr", 4'd3, DECERR);
    ar_send(32'h0, 4'd0, 8'd0, INCR);
    r_expect("oor_intact", pat(0), 4'd0, OKAY, 1'b1, 0);

    // Byte strobes; B held while bready low
    aw_send(32'h20, 4'd2, 8'd1, INCR);
    w_send({32{8'hAA}}, 32'hFFFF_0000, 1'b0);
    w_send({32{8'hBB}}, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b_hold_valid", bus.bvalid, 1'b1);
      check("b_hold_bid", bus.bid, 4'd2);
    end
    b_expect("strb", 4'd2, OKAY);
    w1_exp = {{16{8'hAA}}, {16{8'h22}}};
    ar_send(32'h20, 4'd4, 8'd1, INCR);
    r_expect("strb_w1", w1_exp, 4'd4, OKAY, 1'b0, 0);
    r_expect("strb_w2", {32{8'hBB}}, 4'd4, OKAY, 1'b1, 0);

    // Early wlast on beat 0 of a 2-beat burst
    aw_send(32'h60, 4'd4, 8'd1, INCR);
    w_send({32{8'hCC}}, 32'hFFFF_FFFF, 1'b1);
    b_expect("early", 4'd4, SLVERR);

    // Missing wlast: beats 2 and 3 are drained without writing
    aw_send(32'h80, 4'd6, 8'd1, INCR);
    w_send({32{8'hD0}}, 32'hFFFF_FFFF, 1'b0);
    w_send({32{8'hD1}}, 32'hFFFF_FFFF, 1'b0);
    w_send({32{8'hD2}}, 32'hFFFF_FFFF, 1'b0);
    w_send({32{8'hD3}}, 32'hFFFF_FFFF, 1'b1);
    b_expect("nolast", 4'd6, SLVERR);
    ar_send(32'h60, 4'd8, 8'd3, INCR);
    r_expect("wl_w3", {32{8'hCC}}, 4'd8, OKAY, 1'b0, 0);
    r_expect("wl_w4", {32{8'hD0}}, 4'd8, OKAY, 1'b0, 0);
    r_expect("wl_w5", {32{8'hD1}}, 4'd8, OKAY, 1'b0, 0);
    r_expect("wl_w6", pat(6), 4'd8, OKAY, 1'b1, 0);

    // R back-pressure: rready low for 1-2 cycles before each beat
    ar_send(32'h0, 4'd9, 8'd3, INCR);
    r_expect("bp0", pat(0), 4'd9, OKAY, 1'b0, 1);
    r_expect("bp1", w1_exp, 4'd9, OKAY, 1'b0, 2);
    r_expect("bp2", {32{8'hBB}}, 4'd9, OKAY, 1'b0, 1);
    r_expect("bp3", {32{8'hCC}}, 4'd9, OKAY, 1'b1, 2);
    @(negedge clk);
    check("pre_rst_rd_bursts", rd_bursts, 32'd7);
    check("pre_rst_wr_bursts", wr_bursts, 32'd5);

    // Reset in the middle of a read burst
    ar_send(32'h0, 4'd1, 8'd3, INCR);
    r_expect("mid0", pat(0), 4'd1, OKAY, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", bus.rvalid, 1'b0);
    check("mid_rst_arready", bus.arready, 1'b0);
    check("mid_rst_rdata", bus.rdata, 256'd0);
    @(negedge clk);
    check("mid_rst_rd_bursts", rd_bursts, 32'd0);
    check("mid_rst_wr_bursts", wr_bursts, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", bus.arready, 1'b1);
    check("post_rst_rvalid", bus.rvalid, 1'b0);
    ar_send(32'h20, 4'd2, 8'd0, INCR);
    r_expect("post_rst_mem", w1_exp, 4'd2, OKAY, 1'b1, 0);
    @(negedge clk);
    check("post_rst_rd_bursts", rd_bursts, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
